// File: rtl/mutual_rule_sched.sv
// Rule scheduler for the mutual-exclusion `system` block.
// Each evaluation cycle it samples the client states and the shared token, computes the
// Murphi rule guards, picks one enabled (client, rule) pair round-robin and issues a
// single-cycle one-hot enable pulse. It also flags deadlock (no enabled rule for
// STALL_LIMIT evaluation cycles) and mutual-exclusion violations.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   io_go        scheduling enable
//   io_n_state   client states, client i at [2i+1:2i]; I=0, T=1, C=2, E=3
//   io_x         shared token, 1 = free
//   io_en_a      one-hot rule enable: bit0 Try, bit1 Crit, bit2 Exit, bit3 Idle
//   io_en_i      client index for io_en_a (holds while io_en_a = 0)
//   io_fire      high exactly when io_en_a != 0
//   io_fire_cnt  saturating count of issued rules
//   io_deadlock  sticky deadlock flag
//   io_mutex_err sticky invariant-violation flag
module mutual_rule_sched #(
  parameter int unsigned NCLIENTS    = 3,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned STALL_LIMIT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_go,
  input  logic [2*NCLIENTS-1:0] io_n_state,
  input  logic                  io_x,
  output logic [3:0]            io_en_a,
  output logic [IDX_W-1:0]      io_en_i,
  output logic                  io_fire,
  output logic [CNT_W-1:0]      io_fire_cnt,
  output logic                  io_deadlock,
  output logic                  io_mutex_err
);

  localparam int unsigned NCand  = 4 * NCLIENTS;
  localparam int unsigned PtrW   = $clog2(NCand);
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StEval, StWait, StHalt} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;
  logic [StallW-1:0] stall_q;
  logic [3:0]        en_a_q;
  logic [IDX_W-1:0]  en_i_q;
  logic              fire_q;
  logic [CNT_W-1:0]  fire_cnt_q;
  logic              deadlock_q;
  logic              mutex_err_q;

  // Guards: candidate k = 4*i + r.
  logic [NCand-1:0] cand;
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < NCLIENTS; i++) begin
      cand[4*i+0] = (io_n_state[2*i +: 2] == 2'd0);
      cand[4*i+1] = (io_n_state[2*i +: 2] == 2'd1) && io_x;
      cand[4*i+2] = (io_n_state[2*i +: 2] == 2'd2);
      cand[4*i+3] = (io_n_state[2*i +: 2] == 2'd3);
    end
  end

  // Rotate so that bit 0 is the candidate at ptr, then take the lowest set bit.
  logic [2*NCand-1:0] cand_dbl;
  logic [NCand-1:0]   cand_rot;
  logic               found;
  logic [PtrW-1:0]    sel_off;
  logic [PtrW:0]      sel_sum;
  logic [PtrW-1:0]    sel_k;
  logic [PtrW-1:0]    sel_i_full;
  logic [PtrW-1:0]    ptr_nxt;
  always_comb begin
    cand_dbl = {cand, cand} >> ptr_q;
    cand_rot = cand_dbl[NCand-1:0];
    found    = 1'b0;
    sel_off  = '0;
    for (int j = int'(NCand) - 1; j >= 0; j--) begin
      if (cand_rot[j]) begin
        found   = 1'b1;
        sel_off = PtrW'(j);
      end
    end
    sel_sum = {1'b0, ptr_q} + {1'b0, sel_off};
    if (sel_sum >= (PtrW+1)'(NCand)) begin
      sel_sum = sel_sum - (PtrW+1)'(NCand);
    end
    sel_k      = sel_sum[PtrW-1:0];
    sel_i_full = sel_k >> 2;
    ptr_nxt    = (sel_k == PtrW'(NCand - 1)) ? '0 : sel_k + PtrW'(1);
  end

  // Mutex invariant: at most one client in C, and never C while the token is free.
  int unsigned n_crit;
  logic        mutex_viol;
  always_comb begin
    n_crit = 0;
    for (int unsigned i = 0; i < NCLIENTS; i++) begin
      if (io_n_state[2*i +: 2] == 2'd2) begin
        n_crit = n_crit + 1;
      end
    end
    mutex_viol = (n_crit > 1) || ((n_crit != 0) && io_x);
  end

  logic [StallW-1:0] stall_inc;
  assign stall_inc = stall_q + StallW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      stall_q     <= '0;
      en_a_q      <= '0;
      en_i_q      <= '0;
      fire_q      <= 1'b0;
      fire_cnt_q  <= '0;
      deadlock_q  <= 1'b0;
      mutex_err_q <= 1'b0;
    end else begin
      mutex_err_q <= mutex_err_q | mutex_viol;
      // Pulses last one cycle unless re-armed below.
      en_a_q      <= '0;
      fire_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (io_go) state_q <= StEval;
        end
        StEval: begin
          if (!io_go) begin
            state_q <= StIdle;
          end else if (found) begin
            en_a_q  <= 4'b0001 << sel_k[1:0];
            en_i_q  <= IDX_W'(sel_i_full);
            fire_q  <= 1'b1;
            ptr_q   <= ptr_nxt;
            stall_q <= '0;
            if (fire_cnt_q != '1) fire_cnt_q <= fire_cnt_q + CNT_W'(1);
            state_q <= StWait;
          end else if (stall_inc == StallW'(STALL_LIMIT)) begin
            stall_q    <= stall_inc;
            deadlock_q <= 1'b1;
            state_q    <= StHalt;
          end else begin
            stall_q <= stall_inc;
          end
        end
        // One settle cycle so `system` sees the pulse before guards are re-sampled.
        StWait: begin
          state_q <= io_go ? StEval : StIdle;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign io_en_a      = en_a_q;
  assign io_en_i      = en_i_q;
  assign io_fire      = fire_q;
  assign io_fire_cnt  = fire_cnt_q;
  assign io_deadlock  = deadlock_q;
  assign io_mutex_err = mutex_err_q;

endmodule

// File: tb/tb_mutual_rule_sched.sv
// Directed bench for mutual_rule_sched: fairness, guard blocking, deadlock, mutex
// checker, go-drop / async reset mid-pulse, and counter saturation (second instance).
module tb_mutual_rule_sched;

  logic        clock;
  logic        reset;
  logic        io_go;
  logic [5:0]  io_n_state;
  logic        io_x;
  logic [3:0]  en_a;
  logic [1:0]  en_i;
  logic        fire;
  logic [15:0] fire_cnt;
  logic        deadlock;
  logic        mutex_err;

  logic [3:0]  s_en_a;
  logic [1:0]  s_en_i;
  logic        s_fire;
  logic [1:0]  s_fire_cnt;
  logic        s_deadlock;
  logic        s_mutex_err;

  int n_asserts;
  int n_fail;

  mutual_rule_sched dut (
    .clock        (clock),
    .reset        (reset),
    .io_go        (io_go),
    .io_n_state   (io_n_state),
    .io_x         (io_x),
    .io_en_a      (en_a),
    .io_en_i      (en_i),
    .io_fire      (fire),
    .io_fire_cnt  (fire_cnt),
    .io_deadlock  (deadlock),
    .io_mutex_err (mutex_err)
  );

  mutual_rule_sched #(.CNT_W(2)) sat_dut (
    .clock        (clock),
    .reset        (reset),
    .io_go        (io_go),
    .io_n_state   (io_n_state),
    .io_x         (io_x),
    .io_en_a      (s_en_a),
    .io_en_i      (s_en_i),
    .io_fire      (s_fire),
    .io_fire_cnt  (s_fire_cnt),
    .io_deadlock  (s_deadlock),
    .io_mutex_err (s_mutex_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_asserts  = 0;
    n_fail     = 0;
    reset      = 1'b1;
    io_go      = 1'b0;
    io_n_state = 6'b000000;
    io_x       = 1'b1;
    repeat (2) tick();
    chk("rst_en_a", 32'(en_a), 32'h0);
    chk("rst_en_i", 32'(en_i), 32'h0);
    chk("rst_fire", 32'(fire), 32'h0);
    chk("rst_cnt", 32'(fire_cnt), 32'h0);
    chk("rst_deadlock", 32'(deadlock), 32'h0);
    chk("rst_mutex", 32'(mutex_err), 32'h0);

    // Fairness: (I,I,I), x=1.
    reset = 1'b0;
    io_go = 1'b1;
    tick();
    chk("fair_idle_to_eval", 32'(en_a), 32'h0);
    tick();
    chk("fair1_en_a", 32'(en_a), 32'h1);
    chk("fair1_en_i", 32'(en_i), 32'h0);
    chk("fair1_fire", 32'(fire), 32'h1);
    chk("fair1_cnt", 32'(fire_cnt), 32'h1);
    chk("sat_cnt1", 32'(s_fire_cnt), 32'h1);
    tick();
    chk("fair_wait_en_a", 32'(en_a), 32'h0);
    chk("fair_wait_fire", 32'(fire), 32'h0);
    chk("fair_wait_en_i_hold", 32'(en_i), 32'h0);
    tick();
    chk("fair2_en_a", 32'(en_a), 32'h1);
    chk("fair2_en_i", 32'(en_i), 32'h1);
    chk("fair2_cnt", 32'(fire_cnt), 32'h2);
    chk("sat_cnt2", 32'(s_fire_cnt), 32'h2);
    tick();
    tick();
    chk("fair3_en_i", 32'(en_i), 32'h2);
    chk("sat_cnt3", 32'(s_fire_cnt), 32'h3);
    tick();
    tick();
    chk("fair4_wrap_en_i", 32'(en_i), 32'h0);
    chk("fair4_cnt", 32'(fire_cnt), 32'h4);
    chk("sat_cnt_hold", 32'(s_fire_cnt), 32'h3);

    // Guard blocking: (T,T,I), x=0.
    reset = 1'b1;
    #1;
    io_n_state = 6'b000101;
    io_x       = 1'b0;
    io_go      = 1'b1;
    reset      = 1'b0;
    tick();
    tick();
    chk("guard1_en_a", 32'(en_a), 32'h1);
    chk("guard1_en_i", 32'(en_i), 32'h2);
    tick();
    tick();
    chk("guard2_en_a", 32'(en_a), 32'h1);
    chk("guard2_en_i", 32'(en_i), 32'h2);
    chk("guard_cnt", 32'(fire_cnt), 32'h2);
    chk("guard_mutex", 32'(mutex_err), 32'h0);

    // Deadlock: (T,T,T), x=0.
    reset = 1'b1;
    #1;
    io_n_state = 6'b010101;
    io_x       = 1'b0;
    io_go      = 1'b1;
    reset      = 1'b0;
    tick();
    repeat (7) tick();
    chk("dl_before_limit", 32'(deadlock), 32'h0);
    tick();
    chk("dl_set", 32'(deadlock), 32'h1);
    chk("dl_en_a", 32'(en_a), 32'h0);
    io_n_state = 6'b000000;
    io_x       = 1'b1;
    repeat (4) tick();
    chk("dl_halt_en_a", 32'(en_a), 32'h0);
    chk("dl_halt_cnt", 32'(fire_cnt), 32'h0);
    chk("dl_sticky", 32'(deadlock), 32'h1);
    reset = 1'b1;
    #1;
    chk("dl_async_clear", 32'(deadlock), 32'h0);

    // Mutex checker.
    io_go      = 1'b0;
    io_n_state = 6'b000010;
    io_x       = 1'b0;
    reset      = 1'b0;
    tick();
    chk("mx_legal", 32'(mutex_err), 32'h0);
    io_n_state = 6'b001010;
    tick();
    chk("mx_two_crit", 32'(mutex_err), 32'h1);
    io_n_state = 6'b000000;
    io_x       = 1'b1;
    tick();
    tick();
    chk("mx_sticky", 32'(mutex_err), 32'h1);
    reset = 1'b1;
    #1;
    chk("mx_reset", 32'(mutex_err), 32'h0);
    io_n_state = 6'b000010;
    io_x       = 1'b1;
    reset      = 1'b0;
    tick();
    chk("mx_crit_token_free", 32'(mutex_err), 32'h1);

    // Go drop during a Crit pulse, then async reset during a Try pulse.
    reset = 1'b1;
    #1;
    io_n_state = 6'b000001;
    io_x       = 1'b1;
    io_go      = 1'b1;
    reset      = 1'b0;
    tick();
    tick();
    chk("gd_crit_en_a", 32'(en_a), 32'h2);
    chk("gd_crit_en_i", 32'(en_i), 32'h0);
    io_go = 1'b0;
    tick();
    chk("gd_pulse_end", 32'(en_a), 32'h0);
    chk("gd_fire_end", 32'(fire), 32'h0);
    repeat (3) tick();
    chk("gd_quiet", 32'(en_a), 32'h0);
    chk("gd_cnt", 32'(fire_cnt), 32'h1);
    io_go = 1'b1;
    tick();
    tick();
    chk("rm_en_a", 32'(en_a), 32'h1);
    chk("rm_en_i", 32'(en_i), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_async_en_a", 32'(en_a), 32'h0);
    chk("rm_async_fire", 32'(fire), 32'h0);
    chk("rm_async_cnt", 32'(fire_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
